glb_read_arbiter: RTL
=====================

Name: glb_read_arbiter

Overview:
- Shares the single global-buffer (GLB) SRAM read port between the NoC controllers (filter, ifmap, psum) that each drive a read enable and address.
- Round-robin arbitration with a bounded burst lock, so a streaming controller keeps the port for consecutive reads.
- Returns read data one cycle after each grant, with a per-requester valid.
- Sits between the NoC controllers' GLB read interfaces and the GLB read port.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = filter, 1 = ifmap, 2 = psum); legal range 2..8.
- ADDR_WIDTH, 20, GLB address width.
- DATA_WIDTH, 16, GLB read data width.
- BURST_LEN, 8, maximum consecutive grants to one owner while others wait; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request (equivalent of re_from_glb).
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  NUM_REQ  one-hot grant; read issued this cycle for that requester.
- rvalid  out  NUM_REQ  one-hot; rdata valid for that requester this cycle.
- rdata  out  DATA_WIDTH  broadcast read data (equal to glb_rdata).
- glb_busy  in  1  GLB port unavailable (e.g. DRAM fill); blocks all grants.
- glb_re  out  1  GLB read enable, equal to OR of gnt.
- glb_addr  out  ADDR_WIDTH  address of the granted requester; 0 when no grant.
- glb_rdata  in  DATA_WIDTH  GLB data, valid one cycle after glb_re.

Behaviour:
- Registered state: state {IDLE, BURST}, owner (clog2 NUM_REQ bits), burst_cnt (8 bits), rr_ptr (clog2 NUM_REQ bits), rvalid register.
- Reset (reset=0, asynchronous): state=IDLE, owner=0, burst_cnt=0, rr_ptr=0, rvalid=0. gnt, glb_re and glb_addr are combinational and read 0 while no req is active. An in-flight read's rvalid is dropped.
- gnt is combinational from registered state plus req and glb_busy. A requester sees its grant in the same cycle it holds req.
- glb_busy=1: gnt=0 and glb_re=0; state, owner, burst_cnt and rr_ptr all hold. In BURST the burst resumes with the same owner when busy drops.
- Fresh arbitration: grant the first i with req[i]=1, scanning cyclically from rr_ptr. On that grant: owner<=i, burst_cnt<=1, state<=BURST, rr_ptr<=(i+1) mod NUM_REQ.
- BURST_LEN=1 special case: state stays IDLE; every grant is a fresh arbitration.
- IDLE with no req: no grant; state holds.
- BURST, req[owner]=1 and burst_cnt<BURST_LEN: grant owner, burst_cnt++.
- BURST, req[owner]=1, burst_cnt==BURST_LEN, no other req: grant owner again, burst_cnt<=1. There is no idle bubble.
- BURST, req[owner]=1, burst_cnt==BURST_LEN, another req pending: fresh arbitration in the same cycle, scanning from owner+1. The owner is considered last.
- BURST, req[owner]=0: fresh arbitration in the same cycle (zero-bubble handover). If no req at all: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
- Read return: rvalid<=gnt on every clk edge; rdata=glb_rdata. Latency from gnt to rvalid is exactly 1 cycle.
- Back-to-back grants give back-to-back rvalid.
- Requesters must not change req_addr in a cycle where req=1 and gnt=0.
- Invariants: gnt is one-hot or zero; glb_re is never high while glb_busy=1.
- Counter widths: burst_cnt never exceeds BURST_LEN; rr_ptr wraps modulo NUM_REQ, so a non-power-of-2 NUM_REQ never points at an unused index.

Optional Feature:
- Macro: GLB_ARB_PSUM_PRIORITY_EN.
- Defined: requester NUM_REQ-1 (psum) preempts. If req[NUM_REQ-1]=1 and it is not the owner, it wins the next non-busy cycle regardless of burst_cnt. The preempted owner's burst ends and rr_ptr<=(old owner+1) mod NUM_REQ.
- Undefined: pure round-robin with burst lock as described above.

Test Plan:
- Reset with req=3'b111 held, release reset -> cycle 0: gnt=001, glb_addr=req_addr[0]. Grants stay 001 for 8 cycles (BURST_LEN=8), then 010; rvalid trails gnt by exactly 1 cycle.
- Only req[1] asserted for 20 cycles -> gnt=010 on all 20 cycles with no bubble at the burst_cnt wrap; rvalid=010 on cycles 1..20; rdata=glb_rdata.
- Owner 0 drops req after 3 grants while req[2]=1 -> gnt=100 on the next cycle (zero bubble); rr_ptr ends at 0 after owner 2's burst.
- glb_busy=1 for 4 cycles mid-burst (burst_cnt=5) -> gnt=0, glb_re=0. Busy drops -> same owner granted for exactly 3 more cycles before rotating.
- Reset asserted asynchronously between clock edges the cycle after a grant -> rvalid=0 immediately; state=IDLE and rr_ptr=0 on release.
- With GLB_ARB_PSUM_PRIORITY_EN, owner 0 at burst_cnt=2 and req[2] rising -> gnt=100 on the next cycle. Without the macro, gnt=100 only after owner 0 reaches burst_cnt=8.

Source files
------------

// File: rtl/glb_read_arbiter.sv
// Round-robin arbiter with burst lock for the shared GLB SRAM read port; rdata returns one cycle after grant.
// Optional macro GLB_ARB_PSUM_PRIORITY_EN: requester NUM_REQ-1 (psum) preempts the current burst owner.
module glb_read_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    input  logic                          glb_busy_i,
    output logic                          glb_re_o,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    input  logic [DATA_WIDTH-1:0]         glb_rdata_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_e;

    // With BURST_LEN=1 there is nothing to lock, so every grant stays a fresh arbitration from IDLE.
    localparam state_e GRANT_STATE = (BURST_LEN > 1) ? BURST : IDLE;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] rvalid_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               do_fresh;
    logic [IDX_W-1:0]   fresh_start;
    logic [IDX_W-1:0]   fresh_idx;
    logic [NUM_REQ-1:0] others;
    logic               own_req;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] x);
        return (x == LAST_IDX) ? '0 : x + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = inc_idx(idx);
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rvalid_q <= gnt_o;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        win_vld     = 1'b0;
        win_idx     = owner_q;
        do_fresh    = 1'b0;
        fresh_start = rr_q;
        others      = req_i;
        others[owner_q] = 1'b0;
        own_req     = req_i[owner_q];

        if (!glb_busy_i) begin
`ifdef GLB_ARB_PSUM_PRIORITY_EN
            if (req_i[NUM_REQ-1] && !(state_q == BURST && owner_q == LAST_IDX)) begin
                win_vld = 1'b1;
                win_idx = LAST_IDX;
                owner_d = LAST_IDX;
                cnt_d   = CNT_W'(1);
                state_d = GRANT_STATE;
                rr_d    = (state_q == BURST) ? inc_idx(owner_q) : '0;
            end else
`endif
            if (state_q == IDLE) begin
                do_fresh = |req_i;
            end else if (own_req && (cnt_q < BURST_MAX)) begin
                win_vld = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end else if (own_req && (others == '0)) begin
                win_vld = 1'b1;
                cnt_d   = CNT_W'(1);
            end else if (own_req) begin
                do_fresh    = 1'b1;
                fresh_start = inc_idx(owner_q);
            end else if (|req_i) begin
                do_fresh = 1'b1;
            end else begin
                state_d = IDLE;
                rr_d    = inc_idx(owner_q);
            end
        end

        fresh_idx = rr_pick(req_i, fresh_start);
        if (do_fresh) begin
            win_vld = 1'b1;
            win_idx = fresh_idx;
            owner_d = fresh_idx;
            cnt_d   = CNT_W'(1);
            rr_d    = inc_idx(fresh_idx);
            state_d = GRANT_STATE;
        end
    end

    // Grant and GLB port drive
    always_comb begin
        gnt_o      = '0;
        glb_addr_o = '0;
        if (win_vld) begin
            gnt_o[win_idx] = 1'b1;
            glb_addr_o     = req_addr_i[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign glb_re_o = win_vld;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = glb_rdata_i;

endmodule
